// File: rtl/led_scan_sequencer.sv
// LED matrix scan sequencer: shifts one row/plane of pixels, latches it,
// then displays it for a binary-weighted (BCM) number of ticks.
module led_scan_sequencer #(
    parameter int unsigned COLS       = 32,
    parameter int unsigned ROWS       = 16,
    parameter int unsigned PLANES     = 4,
    parameter int unsigned BASE_TICKS = 2,
    localparam int unsigned COL_W     = $clog2(COLS),
    localparam int unsigned ROW_W     = $clog2(ROWS),
    localparam int unsigned PL_W      = (PLANES > 1) ? $clog2(PLANES) : 1
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             half_enb_i,
    input  logic             run_i,
    output logic             sclk_o,
    output logic             lat_o,
    output logic             blank_o,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o,
    output logic [PL_W-1:0]  plane_o,
    output logic [ROW_W-1:0] row_sel_o,
    output logic             frame_done_o
);

    // Longest display period sets the counter width.
    localparam int unsigned MAX_TICKS = BASE_TICKS << (PLANES - 1);
    localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SCLK_LO = 3'd1,
        SCLK_HI = 3'd2,
        BLANK0  = 3'd3,
        BLANK1  = 3'd4,
        LATCH   = 3'd5,
        DISPLAY = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [PL_W-1:0]    plane_q, plane_d;
    logic [ROW_W-1:0]   row_sel_q, row_sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sclk_q, sclk_d;
    logic               lat_q, lat_d;
    logic               blank_q, blank_d;
    logic               fd_q, fd_d;

    // Next-state, counters and output decode of the next state.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        plane_d   = plane_q;
        row_sel_d = row_sel_q;
        cnt_d     = cnt_q;
        fd_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (half_enb_i && run_i) begin
                    state_d = SCLK_LO;
                    col_d   = '0;
                    row_d   = '0;
                    plane_d = '0;
                end
            end
            SCLK_LO: begin
                if (half_enb_i) state_d = SCLK_HI;
            end
            SCLK_HI: begin
                if (half_enb_i) begin
                    if (col_q == COL_W'(COLS - 1)) begin
                        state_d = BLANK0;
                        col_d   = '0;
                    end else begin
                        col_d   = col_q + COL_W'(1);
                        state_d = SCLK_LO;
                    end
                end
            end
            BLANK0: begin
                if (half_enb_i) state_d = BLANK1;
            end
            BLANK1: begin
                if (half_enb_i) state_d = LATCH;
            end
            LATCH: begin
                if (half_enb_i) begin
                    row_sel_d = row_q;
                    cnt_d     = CNT_W'(BASE_TICKS) << plane_q;
                    state_d   = DISPLAY;
                end
            end
            DISPLAY: begin
                if (half_enb_i) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        if (plane_q != PL_W'(PLANES - 1)) begin
                            plane_d = plane_q + PL_W'(1);
                            state_d = SCLK_LO;
                        end else if (row_q != ROW_W'(ROWS - 1)) begin
                            plane_d = '0;
                            row_d   = row_q + ROW_W'(1);
                            state_d = SCLK_LO;
                        end else begin
                            plane_d = '0;
                            row_d   = '0;
                            fd_d    = 1'b1;
                            state_d = run_i ? SCLK_LO : IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        sclk_d  = (state_d == SCLK_HI);
        lat_d   = (state_d == LATCH);
        blank_d = (state_d == IDLE) || (state_d == BLANK1) || (state_d == LATCH);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            plane_q   <= '0;
            row_sel_q <= '0;
            cnt_q     <= '0;
            sclk_q    <= 1'b0;
            lat_q     <= 1'b0;
            blank_q   <= 1'b1;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            plane_q   <= plane_d;
            row_sel_q <= row_sel_d;
            cnt_q     <= cnt_d;
            sclk_q    <= sclk_d;
            lat_q     <= lat_d;
            blank_q   <= blank_d;
            fd_q      <= fd_d;
        end
    end

    assign sclk_o       = sclk_q;
    assign lat_o        = lat_q;
    assign blank_o      = blank_q;
    assign col_o        = col_q;
    assign row_o        = row_q;
    assign plane_o      = plane_q;
    assign row_sel_o    = row_sel_q;
    assign frame_done_o = fd_q;

endmodule

// File: tb/tb_led_scan_sequencer.sv
// Directed bench for led_scan_sequencer: 4x2x2 instance plus a single-plane 2x2 instance.
module tb_led_scan_sequencer;

    logic clk = 1'b0;
    logic rst, he, run, run_b;

    logic       a_sclk, a_lat, a_blank, a_fd;
    logic [1:0] a_col;
    logic [0:0] a_row, a_plane, a_row_sel;
    logic       b_sclk, b_lat, b_blank, b_fd;
    logic [0:0] b_col, b_row, b_plane, b_row_sel;

    int n_err = 0;
    int n_chk = 0;
    int mode  = 0;
    int cyc   = 0;
    int edges = 0;
    int a_rise, a_lat_cyc, a_blank_lo, a_fd_n, a_unstable;
    int b_fd_n, b_plane_nz;

    always #5 clk = ~clk;

    led_scan_sequencer #(.COLS(4), .ROWS(2), .PLANES(2), .BASE_TICKS(2)) u_a (
        .clk(clk), .rst_i(rst), .half_enb_i(he), .run_i(run),
        .sclk_o(a_sclk), .lat_o(a_lat), .blank_o(a_blank), .col_o(a_col),
        .row_o(a_row), .plane_o(a_plane), .row_sel_o(a_row_sel), .frame_done_o(a_fd)
    );

    led_scan_sequencer #(.COLS(2), .ROWS(2), .PLANES(1), .BASE_TICKS(2)) u_b (
        .clk(clk), .rst_i(rst), .half_enb_i(he), .run_i(run_b),
        .sclk_o(b_sclk), .lat_o(b_lat), .blank_o(b_blank), .col_o(b_col),
        .row_o(b_row), .plane_o(b_plane), .row_sel_o(b_row_sel), .frame_done_o(b_fd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        a_rise = 0; a_lat_cyc = 0; a_blank_lo = 0; a_fd_n = 0; a_unstable = 0;
        b_fd_n = 0; b_plane_nz = 0;
    endtask

    // One clock: drive half_enb per mode, then sample 1ns after the edge.
    task automatic step();
        logic [8:0] prev_snap;
        logic       prev_sclk;
        logic       he_used;
        if (mode == 1) he = 1'b1;
        else if (mode == 3) he = ((cyc % 3) == 0);
        prev_snap = {a_sclk, a_lat, a_blank, a_col, a_row, a_plane, a_row_sel};
        prev_sclk = a_sclk;
        he_used   = he;
        @(posedge clk);
        #1;
        cyc++;
        edges++;
        if (a_sclk && !prev_sclk) a_rise++;
        if (a_lat) a_lat_cyc++;
        if (!a_blank) a_blank_lo++;
        if (a_fd) a_fd_n++;
        if (!he_used && ({a_sclk, a_lat, a_blank, a_col, a_row, a_plane, a_row_sel} != prev_snap))
            a_unstable++;
        if (b_fd) b_fd_n++;
        if (b_plane != 1'b0) b_plane_nz++;
    endtask

    task automatic run_to(input int n);
        while (edges < n) step();
    endtask

    // Reset with half_enb and run active to show reset priority.
    task automatic do_reset();
        rst = 1'b1; he = 1'b1; run = 1'b1; run_b = 1'b1; mode = 0;
        step();
        rst = 1'b0;
        clear_counts();
        edges = 0;
        cyc   = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sclk"},    a_sclk, 0);
        chk({tag, "_lat"},     a_lat, 0);
        chk({tag, "_blank"},   a_blank, 1);
        chk({tag, "_col"},     a_col, 0);
        chk({tag, "_row"},     a_row, 0);
        chk({tag, "_plane"},   a_plane, 0);
        chk({tag, "_row_sel"}, a_row_sel, 0);
        chk({tag, "_fd"},      a_fd, 0);
    endtask

    initial begin
        rst = 1'b0; he = 1'b0; run = 1'b0; run_b = 1'b0;
        clear_counts();

        // Full-rate scan of two frames.
        do_reset();
        chk_reset_vals("rst0");
        chk("rst0_b_blank", b_blank, 1);
        run = 1'b1; run_b = 1'b0; mode = 1;
        run_to(1);  chk("e1_sclk", a_sclk, 0); chk("e1_blank", a_blank, 0); chk("e1_col", a_col, 0);
        run_to(2);  chk("e2_sclk", a_sclk, 1); chk("e2_col", a_col, 0);
        run_to(8);  chk("e8_sclk", a_sclk, 1); chk("e8_col", a_col, 3);
        run_to(9);  chk("e9_sclk", a_sclk, 0); chk("e9_blank", a_blank, 0); chk("e9_col", a_col, 0);
        run_to(10); chk("e10_blank", a_blank, 1); chk("e10_lat", a_lat, 0);
        run_to(11); chk("e11_lat", a_lat, 1); chk("e11_blank", a_blank, 1);
        run_to(12); chk("e12_lat", a_lat, 0); chk("e12_blank", a_blank, 0); chk("e12_rsel", a_row_sel, 0);
        run_to(13); chk("e13_blank", a_blank, 0);
        run_to(14); chk("e14_sclk", a_sclk, 0); chk("e14_plane", a_plane, 1); chk("e14_row", a_row, 0);
        run_to(40); chk("e40_row", a_row, 1); chk("e40_plane", a_plane, 0); chk("e40_rsel", a_row_sel, 1);
        run_to(56);
        chk("e56_fd", a_fd, 0);
        chk("f1_sclk_rises", 32'(a_rise), 16);
        chk("f1_lat_cycles", 32'(a_lat_cyc), 4);
        chk("f1_blank_lo", 32'(a_blank_lo), 48);
        run_to(57); chk("e57_fd", a_fd, 1); chk("e57_row", a_row, 0); chk("e57_plane", a_plane, 0);
        run_to(58); chk("e58_fd", a_fd, 0); chk("e58_sclk", a_sclk, 1);
        run_to(110);
        chk("e110_row", a_row, 1); chk("e110_plane", a_plane, 1); chk("e110_blank", a_blank, 0);
        chk("e110_fd_count", 32'(a_fd_n), 1);

        // Reset in DISPLAY of row 1 plane 1, then restart.
        do_reset();
        chk_reset_vals("rst_disp");
        run = 1'b1; run_b = 1'b0; mode = 1;
        run_to(1);  chk("rs1_row", a_row, 0); chk("rs1_plane", a_plane, 0); chk("rs1_blank", a_blank, 0);
        run_to(12); chk("rs12_rsel", a_row_sel, 0); chk("rs12_blank", a_blank, 0);

        // half_enb every third cycle.
        do_reset();
        run = 1'b1; run_b = 1'b0; mode = 3;
        run_to(31);  chk("s31_lat", a_lat, 1);
        run_to(33);  chk("s33_lat", a_lat, 1);
        run_to(34);  chk("s34_lat", a_lat, 0); chk("s34_blank", a_blank, 0);
        run_to(168);
        chk("s_lat_cycles", 32'(a_lat_cyc), 12);
        chk("s_sclk_rises", 32'(a_rise), 16);
        chk("s_unstable", 32'(a_unstable), 0);
        chk("s_fd_count", 32'(a_fd_n), 0);
        run_to(169); chk("s169_fd", a_fd, 1);
        run_to(170); chk("s170_fd", a_fd, 0);

        // run dropped at tick 10: frame completes, then idle.
        do_reset();
        run = 1'b1; run_b = 1'b0; mode = 1;
        run_to(9);
        run = 1'b0;
        run_to(56); chk("r56_rises", 32'(a_rise), 16); chk("r56_fd", 32'(a_fd_n), 0);
        run_to(57); chk("r57_fd", a_fd, 1); chk("r57_blank", a_blank, 1); chk("r57_sclk", a_sclk, 0);
        run_to(77);
        chk("r77_rises", 32'(a_rise), 16);
        chk("r77_blank", a_blank, 1);
        chk("r77_blank_lo", 32'(a_blank_lo), 48);
        chk("r77_fd_count", 32'(a_fd_n), 1);

        // Single-plane instance.
        do_reset();
        run = 1'b0; run_b = 1'b1; mode = 1;
        run_to(9);  chk("b9_row", b_row, 0); chk("b9_blank", b_blank, 0);
        run_to(10); chk("b10_row", b_row, 1); chk("b10_plane", b_plane, 0);
        run_to(18); chk("b18_fd", b_fd, 0);
        run_to(19); chk("b19_fd", b_fd, 1); chk("b19_row", b_row, 0);
        run_to(37);
        chk("b37_fd", b_fd, 1);
        chk("b37_fd_count", 32'(b_fd_n), 2);
        chk("b_plane_nonzero", 32'(b_plane_nz), 0);
        chk("b_a_idle_blank", a_blank, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
